// File: rtl/logic_axi4_stream_pkg.sv
// Shared constants, slice state encoding and payload sizing for the AXI4-Stream pipeline.
package logic_axi4_stream_pkg;

    localparam int STAGES_MAX = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } slice_state_e;

    // Width of {tlast?, tid, tuser, tdest, tkeep?, tstrb?, tdata} as carried through the slices.
    function automatic int payload_width(
        input int tdata_bytes,
        input int tdest_width,
        input int tuser_width,
        input int tid_width,
        input bit use_tkeep,
        input bit use_tstrb,
        input bit use_tlast
    );
        int w;
        w = tdata_bytes * 8 + tdest_width + tuser_width + tid_width;
        if (use_tkeep) w += tdata_bytes;
        if (use_tstrb) w += tdata_bytes;
        if (use_tlast) w += 1;
        return w;
    endfunction

endpackage

// File: rtl/logic_axi4_stream_skid_slice.sv
// Full-throughput skid slice: registered forward path and registered ready.
module logic_axi4_stream_skid_slice
    import logic_axi4_stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             rx_tvalid,
    output logic             rx_tready,
    input  logic [WIDTH-1:0] rx_tdata,
    output logic             tx_tvalid,
    input  logic             tx_tready,
    output logic [WIDTH-1:0] tx_tdata
);

    slice_state_e     state, state_next;
    logic             ready;
    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] skid_data;
    logic             accept, drain;
    logic             load_out, load_skid, skid_to_out;

    assign tx_tvalid = (state != EMPTY);
    assign tx_tdata  = out_data;
    assign rx_tready = ready;
    assign accept    = rx_tvalid && ready;
    assign drain     = tx_tvalid && tx_tready;

    always_comb begin
        state_next  = state;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    load_out   = 1'b1;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    load_skid  = 1'b1;
                    state_next = FULL;
                end else if (drain) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                // ready is low here, so nothing new can arrive while the skid drains
                if (drain) begin
                    skid_to_out = 1'b1;
                    state_next  = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= EMPTY;
            ready <= 1'b0;
        end else begin
            state <= state_next;
            ready <= (state_next != FULL);
        end
    end

    always_ff @(posedge aclk) begin
        if (load_out)         out_data <= rx_tdata;
        else if (skid_to_out) out_data <= skid_data;
        if (load_skid)        skid_data <= rx_tdata;
    end

endmodule

// File: rtl/logic_axi4_stream_pipeline.sv
// AXI4-Stream register pipeline: STAGES skid slices on a packed payload, with sideband tie-offs.
module logic_axi4_stream_pipeline
    import logic_axi4_stream_pkg::*;
#(
    parameter int TDATA_BYTES = 4,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = 1,
    parameter bit USE_TKEEP   = 1'b1,
    parameter bit USE_TSTRB   = 1'b1,
    parameter bit USE_TLAST   = 1'b1,
    parameter int STAGES      = 1
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        rx_tvalid,
    output logic                        rx_tready,
    input  logic                        rx_tlast,
    input  logic [TDATA_BYTES-1:0][7:0] rx_tdata,
    input  logic [TDATA_BYTES-1:0]      rx_tstrb,
    input  logic [TDATA_BYTES-1:0]      rx_tkeep,
    input  logic [TDEST_WIDTH-1:0]      rx_tdest,
    input  logic [TUSER_WIDTH-1:0]      rx_tuser,
    input  logic [TID_WIDTH-1:0]        rx_tid,
    output logic                        tx_tvalid,
    input  logic                        tx_tready,
    output logic                        tx_tlast,
    output logic [TDATA_BYTES-1:0][7:0] tx_tdata,
    output logic [TDATA_BYTES-1:0]      tx_tstrb,
    output logic [TDATA_BYTES-1:0]      tx_tkeep,
    output logic [TDEST_WIDTH-1:0]      tx_tdest,
    output logic [TUSER_WIDTH-1:0]      tx_tuser,
    output logic [TID_WIDTH-1:0]        tx_tid
);

    localparam int DW     = TDATA_BYTES * 8;
    localparam int KB     = TDATA_BYTES;
    localparam int STRB_W = USE_TSTRB ? KB : 0;
    localparam int KEEP_W = USE_TKEEP ? KB : 0;
    localparam int O_STRB = DW;
    localparam int O_KEEP = O_STRB + STRB_W;
    localparam int O_DEST = O_KEEP + KEEP_W;
    localparam int O_USER = O_DEST + TDEST_WIDTH;
    localparam int O_ID   = O_USER + TUSER_WIDTH;
    localparam int O_LAST = O_ID + TID_WIDTH;
    localparam int W      = payload_width(TDATA_BYTES, TDEST_WIDTH, TUSER_WIDTH, TID_WIDTH,
                                          USE_TKEEP, USE_TSTRB, USE_TLAST);

    if (STAGES < 0 || STAGES > STAGES_MAX) begin : g_bad_stages
        $fatal(1, "logic_axi4_stream_pipeline: STAGES out of range 0..16");
    end

    wire [W-1:0]            rx_pl;
    wire [W-1:0]            tx_pl;
    wire [STAGES:0]         vld_pipe;
    wire [STAGES:0]         rdy_pipe;
    wire [STAGES:0][W-1:0]  pl_pipe;

    // Pack: optional fields only take payload bits when enabled
    assign rx_pl[DW-1:0]                  = rx_tdata;
    assign rx_pl[O_DEST +: TDEST_WIDTH]   = rx_tdest;
    assign rx_pl[O_USER +: TUSER_WIDTH]   = rx_tuser;
    assign rx_pl[O_ID   +: TID_WIDTH]     = rx_tid;
    if (USE_TSTRB) begin : g_rx_strb
        assign rx_pl[O_STRB +: KB] = rx_tstrb;
    end
    if (USE_TKEEP) begin : g_rx_keep
        assign rx_pl[O_KEEP +: KB] = rx_tkeep;
    end
    if (USE_TLAST) begin : g_rx_last
        assign rx_pl[O_LAST] = rx_tlast;
    end

    // With STAGES=0 the chain collapses to plain wires, ready included
    assign vld_pipe[0]      = rx_tvalid;
    assign pl_pipe[0]       = rx_pl;
    assign rx_tready        = rdy_pipe[0];
    assign rdy_pipe[STAGES] = tx_tready;
    assign tx_tvalid        = vld_pipe[STAGES];
    assign tx_pl            = pl_pipe[STAGES];

    for (genvar i = 0; i < STAGES; i++) begin : g_slice
        logic_axi4_stream_skid_slice #(
            .WIDTH(W)
        ) u_slice (
            .aclk      (aclk),
            .areset    (areset),
            .rx_tvalid (vld_pipe[i]),
            .rx_tready (rdy_pipe[i]),
            .rx_tdata  (pl_pipe[i]),
            .tx_tvalid (vld_pipe[i+1]),
            .tx_tready (rdy_pipe[i+1]),
            .tx_tdata  (pl_pipe[i+1])
        );
    end

    assign tx_tdata = tx_pl[DW-1:0];
    assign tx_tdest = tx_pl[O_DEST +: TDEST_WIDTH];
    assign tx_tuser = tx_pl[O_USER +: TUSER_WIDTH];
    assign tx_tid   = tx_pl[O_ID +: TID_WIDTH];

    if (USE_TKEEP) begin : g_tx_keep
        assign tx_tkeep = tx_pl[O_KEEP +: KB];
    end else begin : g_tx_keep_tie
        assign tx_tkeep = '1;
    end

    if (USE_TSTRB) begin : g_tx_strb
        assign tx_tstrb = tx_pl[O_STRB +: KB];
    end else begin : g_tx_strb_tie
        assign tx_tstrb = tx_tkeep;
    end

    if (USE_TLAST) begin : g_tx_last
        assign tx_tlast = tx_pl[O_LAST];
    end else begin : g_tx_last_tie
        assign tx_tlast = 1'b1;
    end

    // Inputs that some parameter sets leave unconnected
    logic unused_inputs;
    assign unused_inputs = ^{aclk, areset, rx_tkeep, rx_tstrb, rx_tlast};

endmodule

// File: tb/tb_logic_axi4_stream_pipeline.sv
// Directed bench: five pipeline instances (STAGES 0..3 and a sideband-stripped one) on a shared Rx.
module tb_logic_axi4_stream_pipeline;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        rx_tvalid = 1'b0;
    logic        rx_tlast = 1'b0;
    logic [31:0] rx_tdata = '0;
    logic [3:0]  rx_tstrb = '0;
    logic [3:0]  rx_tkeep = '0;
    logic [3:0]  rx_tdest = '0;
    logic [2:0]  rx_tuser = '0;
    logic [1:0]  rx_tid = '0;

    // index: 0..3 = STAGES 0..3, 4 = STAGES 1 with all USE_* off
    logic        t_vld [5];
    logic        t_rdy [5];
    logic        r_rdy [5];
    logic        t_last[5];
    logic [31:0] t_data[5];
    logic [3:0]  t_strb[5];
    logic [3:0]  t_keep[5];
    logic [3:0]  t_dest[5];
    logic [2:0]  t_user[5];
    logic [1:0]  t_id  [5];

    int n_chk = 0;
    int n_fail = 0;

    always #5 aclk = ~aclk;

    logic_axi4_stream_pipeline #(.TDATA_BYTES(4), .TDEST_WIDTH(4), .TUSER_WIDTH(3), .TID_WIDTH(2), .STAGES(0)) d0 (
        .aclk(aclk), .areset(areset), .rx_tvalid(rx_tvalid), .rx_tready(r_rdy[0]), .rx_tlast(rx_tlast),
        .rx_tdata(rx_tdata), .rx_tstrb(rx_tstrb), .rx_tkeep(rx_tkeep), .rx_tdest(rx_tdest), .rx_tuser(rx_tuser),
        .rx_tid(rx_tid), .tx_tvalid(t_vld[0]), .tx_tready(t_rdy[0]), .tx_tlast(t_last[0]), .tx_tdata(t_data[0]),
        .tx_tstrb(t_strb[0]), .tx_tkeep(t_keep[0]), .tx_tdest(t_dest[0]), .tx_tuser(t_user[0]), .tx_tid(t_id[0]));

    logic_axi4_stream_pipeline #(.TDATA_BYTES(4), .TDEST_WIDTH(4), .TUSER_WIDTH(3), .TID_WIDTH(2), .STAGES(1)) d1 (
        .aclk(aclk), .areset(areset), .rx_tvalid(rx_tvalid), .rx_tready(r_rdy[1]), .rx_tlast(rx_tlast),
        .rx_tdata(rx_tdata), .rx_tstrb(rx_tstrb), .rx_tkeep(rx_tkeep), .rx_tdest(rx_tdest), .rx_tuser(rx_tuser),
        .rx_tid(rx_tid), .tx_tvalid(t_vld[1]), .tx_tready(t_rdy[1]), .tx_tlast(t_last[1]), .tx_tdata(t_data[1]),
        .tx_tstrb(t_strb[1]), .tx_tkeep(t_keep[1]), .tx_tdest(t_dest[1]), .tx_tuser(t_user[1]), .tx_tid(t_id[1]));

    logic_axi4_stream_pipeline #(.TDATA_BYTES(4), .TDEST_WIDTH(4), .TUSER_WIDTH(3), .TID_WIDTH(2), .STAGES(2)) d2 (
        .aclk(aclk), .areset(areset), .rx_tvalid(rx_tvalid), .rx_tready(r_rdy[2]), .rx_tlast(rx_tlast),
        .rx_tdata(rx_tdata), .rx_tstrb(rx_tstrb), .rx_tkeep(rx_tkeep), .rx_tdest(rx_tdest), .rx_tuser(rx_tuser),
        .rx_tid(rx_tid), .tx_tvalid(t_vld[2]), .tx_tready(t_rdy[2]), .tx_tlast(t_last[2]), .tx_tdata(t_data[2]),
        .tx_tstrb(t_strb[2]), .tx_tkeep(t_keep[2]), .tx_tdest(t_dest[2]), .tx_tuser(t_user[2]), .tx_tid(t_id[2]));

    logic_axi4_stream_pipeline #(.TDATA_BYTES(4), .TDEST_WIDTH(4), .TUSER_WIDTH(3), .TID_WIDTH(2), .STAGES(3)) d3 (
        .aclk(aclk), .areset(areset), .rx_tvalid(rx_tvalid), .rx_tready(r_rdy[3]), .rx_tlast(rx_tlast),
        .rx_tdata(rx_tdata), .rx_tstrb(rx_tstrb), .rx_tkeep(rx_tkeep), .rx_tdest(rx_tdest), .rx_tuser(rx_tuser),
        .rx_tid(rx_tid), .tx_tvalid(t_vld[3]), .tx_tready(t_rdy[3]), .tx_tlast(t_last[3]), .tx_tdata(t_data[3]),
        .tx_tstrb(t_strb[3]), .tx_tkeep(t_keep[3]), .tx_tdest(t_dest[3]), .tx_tuser(t_user[3]), .tx_tid(t_id[3]));

    logic_axi4_stream_pipeline #(.TDATA_BYTES(4), .TDEST_WIDTH(4), .TUSER_WIDTH(3), .TID_WIDTH(2), .STAGES(1),
                                 .USE_TKEEP(1'b0), .USE_TSTRB(1'b0), .USE_TLAST(1'b0)) dn (
        .aclk(aclk), .areset(areset), .rx_tvalid(rx_tvalid), .rx_tready(r_rdy[4]), .rx_tlast(rx_tlast),
        .rx_tdata(rx_tdata), .rx_tstrb(rx_tstrb), .rx_tkeep(rx_tkeep), .rx_tdest(rx_tdest), .rx_tuser(rx_tuser),
        .rx_tid(rx_tid), .tx_tvalid(t_vld[4]), .tx_tready(t_rdy[4]), .tx_tlast(t_last[4]), .tx_tdata(t_data[4]),
        .tx_tstrb(t_strb[4]), .tx_tkeep(t_keep[4]), .tx_tdest(t_dest[4]), .tx_tuser(t_user[4]), .tx_tid(t_id[4]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Leaves the caller just after the first edge with areset low (ready already up)
    task automatic rst();
        areset = 1'b1;
        rx_tvalid = 1'b0;
        repeat (2) tick();
        areset = 1'b0;
        tick();
    endtask

    function automatic logic [63:0] pk(input logic l, input logic [1:0] id, input logic [2:0] u,
                                       input logic [3:0] d, input logic [3:0] k, input logic [3:0] s,
                                       input logic [31:0] dt);
        return 64'({l, id, u, d, k, s, dt});
    endfunction

    initial begin
        int s, got, first_acc, first_tx, last_tx, gaps, sent, spur, bad_stable, lat, extra;
        logic        prev_hold;
        logic [63:0] prev_pl, cur, exp_pl;
        logic [63:0] sb[$];

        for (int i = 0; i < 5; i++) t_rdy[i] = 1'b0;

        // 1: reset held 3 cycles with rx_tvalid up
        areset = 1'b1;
        rx_tvalid = 1'b1;
        rx_tdata = 32'h55;
        repeat (3) begin
            tick();
            chk("t1_rst_rdy", 64'(r_rdy[1]), 64'd0);
            chk("t1_rst_vld", 64'(t_vld[1]), 64'd0);
        end
        areset = 1'b0;
        tick();
        chk("t1_rdy_after", 64'(r_rdy[1]), 64'd1);
        chk("t1_vld_after", 64'(t_vld[1]), 64'd0);
        rx_tvalid = 1'b0;

        // 2: 100 back-to-back beats through 3 stages
        rst();
        t_rdy[3] = 1'b1;
        s = 0; got = 0; first_acc = -1; first_tx = -1; last_tx = 0; gaps = 0;
        for (int c = 0; c < 300 && got < 100; c++) begin
            rx_tvalid = (s < 100);
            rx_tdata = 32'(s);
            #1;
            if (s < 100 && !r_rdy[3]) gaps++;
            if (t_vld[3]) begin
                chk("t2_data", 64'(t_data[3]), 64'(got));
                if (first_tx < 0) first_tx = c;
                last_tx = c;
                got++;
            end
            if (rx_tvalid && r_rdy[3]) begin
                if (first_acc < 0) first_acc = c;
                s++;
            end
            tick();
        end
        rx_tvalid = 1'b0;
        chk("t2_count", 64'(got), 64'd100);
        chk("t2_latency", 64'(first_tx - first_acc), 64'd3);
        chk("t2_rate", 64'(last_tx - first_tx), 64'd99);
        chk("t2_rdy_gaps", 64'(gaps), 64'd0);

        // 3: backpressure fills 2 stages with exactly 4 beats, then drains in order
        rst();
        t_rdy[2] = 1'b0;
        s = 0;
        for (int c = 0; c < 12; c++) begin
            rx_tvalid = 1'b1;
            rx_tdata = 32'(s);
            #1;
            if (r_rdy[2]) s++;
            tick();
        end
        chk("t3_accepted", 64'(s), 64'd4);
        chk("t3_rdy_low", 64'(r_rdy[2]), 64'd0);
        chk("t3_head_vld", 64'(t_vld[2]), 64'd1);
        chk("t3_head_data", 64'(t_data[2]), 64'd0);
        t_rdy[2] = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 10; c++) begin
            rx_tvalid = 1'b1;
            rx_tdata = 32'(s);
            #1;
            if (t_vld[2]) begin
                chk("t3_order", 64'(t_data[2]), 64'(got));
                got++;
            end
            if (r_rdy[2]) s++;
            tick();
        end
        rx_tvalid = 1'b0;
        chk("t3_drained", 64'(got), 64'd10);

        // 4: random valid/ready with full sideband, scoreboarded
        rst();
        sent = 0; got = 0; spur = 0; bad_stable = 0;
        prev_hold = 1'b0; prev_pl = '0;
        for (int c = 0; c < 60000 && got < 10000; c++) begin
            rx_tvalid = (sent < 10000) && ($urandom_range(0, 1) == 1);
            rx_tdata  = $urandom;
            rx_tkeep  = 4'($urandom);
            rx_tstrb  = 4'($urandom);
            rx_tdest  = 4'($urandom);
            rx_tuser  = 3'($urandom);
            rx_tid    = 2'($urandom);
            rx_tlast  = 1'($urandom);
            t_rdy[1]  = 1'($urandom_range(0, 1));
            #1;
            cur = pk(t_last[1], t_id[1], t_user[1], t_dest[1], t_keep[1], t_strb[1], t_data[1]);
            if (prev_hold && (!t_vld[1] || cur !== prev_pl)) bad_stable++;
            if (rx_tvalid && r_rdy[1]) begin
                sb.push_back(pk(rx_tlast, rx_tid, rx_tuser, rx_tdest, rx_tkeep, rx_tstrb, rx_tdata));
                sent++;
            end
            if (t_vld[1] && t_rdy[1]) begin
                if (sb.size() == 0) spur++;
                else begin
                    exp_pl = sb.pop_front();
                    chk("t4_beat", cur, exp_pl);
                end
                got++;
            end
            prev_hold = t_vld[1] && !t_rdy[1];
            prev_pl = cur;
            tick();
        end
        rx_tvalid = 1'b0;
        chk("t4_received", 64'(got), 64'd10000);
        chk("t4_spurious", 64'(spur), 64'd0);
        chk("t4_leftover", 64'(sb.size()), 64'd0);
        chk("t4_stability", 64'(bad_stable), 64'd0);

        // 5: STAGES=0 pass-through and sideband tie-offs
        rst();
        t_rdy[0] = 1'b0;
        t_rdy[4] = 1'b1;
        rx_tvalid = 1'b1;
        rx_tdata = 32'h1234_5678;
        rx_tkeep = 4'h3;
        rx_tstrb = 4'h1;
        rx_tlast = 1'b0;
        rx_tdest = 4'h5;
        rx_tuser = 3'h6;
        rx_tid = 2'h2;
        #1;
        chk("t0_vld", 64'(t_vld[0]), 64'd1);
        chk("t0_rdy_lo", 64'(r_rdy[0]), 64'd0);
        chk("t0_data", 64'(t_data[0]), 64'h1234_5678);
        chk("t0_keep", 64'(t_keep[0]), 64'h3);
        chk("t0_strb", 64'(t_strb[0]), 64'h1);
        chk("t0_last", 64'(t_last[0]), 64'd0);
        chk("t0_dest", 64'(t_dest[0]), 64'h5);
        t_rdy[0] = 1'b1;
        #1;
        chk("t0_rdy_hi", 64'(r_rdy[0]), 64'd1);
        tick();
        rx_tvalid = 1'b0;
        #1;
        chk("t0_vld_drop", 64'(t_vld[0]), 64'd0);
        chk("t5_vld", 64'(t_vld[4]), 64'd1);
        chk("t5_data", 64'(t_data[4]), 64'h1234_5678);
        chk("t5_keep", 64'(t_keep[4]), 64'hF);
        chk("t5_strb", 64'(t_strb[4]), 64'hF);
        chk("t5_last", 64'(t_last[4]), 64'd1);
        chk("t5_dest", 64'(t_dest[4]), 64'h5);
        chk("t5_user", 64'(t_user[4]), 64'h6);
        chk("t5_id", 64'(t_id[4]), 64'h2);
        tick();

        // 6: reset with 3 beats in flight, then a fresh beat 0xAB
        rst();
        t_rdy[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rx_tvalid = 1'b1;
            rx_tdata = 32'(i + 1);
            #1;
            chk("t6_fill_rdy", 64'(r_rdy[2]), 64'd1);
            tick();
        end
        rx_tvalid = 1'b1;
        rx_tdata = 32'hEE;
        areset = 1'b1;
        tick();
        areset = 1'b0;
        rx_tvalid = 1'b0;
        #1;
        chk("t6_vld_clr", 64'(t_vld[2]), 64'd0);
        chk("t6_rdy_rst", 64'(r_rdy[2]), 64'd0);
        tick();
        t_rdy[2] = 1'b1;
        rx_tvalid = 1'b1;
        rx_tdata = 32'hAB;
        #1;
        chk("t6_rdy_back", 64'(r_rdy[2]), 64'd1);
        tick();
        rx_tvalid = 1'b0;
        lat = -1; extra = 0;
        for (int c = 1; c <= 8; c++) begin
            #1;
            if (t_vld[2]) begin
                if (lat < 0) begin
                    lat = c;
                    chk("t6_data", 64'(t_data[2]), 64'hAB);
                end else begin
                    extra++;
                end
            end
            tick();
        end
        chk("t6_latency", 64'(lat), 64'd2);
        chk("t6_extra", 64'(extra), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
